// File: rtl/dma_arbiter_if.sv
// Bundle of requester-side and memory-side DMA signals for dma_arbiter.
// Handshake: req and mem_req are levels; ack/done/mem_ack/mem_done are one-cycle pulses, one transfer in flight at a time.
interface dma_arbiter_if #(
  parameter int N  = 4,
  parameter int AW = 22
);
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;
  logic [N-1:0]    rnw;
  logic [N*8-1:0]  wd;
  logic [N-1:0]    ack;
  logic [N-1:0]    done;
  logic [7:0]      rd;
  logic            mem_req;
  logic [AW-1:0]   mem_addr;
  logic            mem_rnw;
  logic [7:0]      mem_wd;
  logic            mem_ack;
  logic            mem_done;
  logic [7:0]      mem_rd;

  // Arbiter side
  modport master (
    input  req, addr, rnw, wd, mem_ack, mem_done, mem_rd,
    output ack, done, rd, mem_req, mem_addr, mem_rnw, mem_wd
  );

  // Requesters plus memory sequencer side
  modport slave (
    output req, addr, rnw, wd, mem_ack, mem_done, mem_rd,
    input  ack, done, rd, mem_req, mem_addr, mem_rnw, mem_wd
  );
endinterface

// File: rtl/dma_arbiter.sv
// Round-robin arbiter sharing one byte-wide memory DMA port among N requesters.
// Optional DMA_ARB_BURST_EN lets the previous winner keep the port for up to BURST_MAX grants.
module dma_arbiter #(
  parameter int N         = 4,
  parameter int AW        = 22,
  parameter int BURST_MAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  dma_arbiter_if.master      bus,
  output logic [1:0]         o_state
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;

  if (N < 2 || N > 8 || BURST_MAX < 1 || BURST_MAX > 255) begin : g_param_check
    $error("dma_arbiter: parameter out of range");
  end

  state_t        r_state, w_next_state;
  logic [IW-1:0] r_ptr, r_sel;
  logic [N-1:0]  r_ack, r_done;
  logic [7:0]    r_rd;
  logic          r_mem_req, r_mem_rnw;
  logic [AW-1:0] r_mem_addr;
  logic [7:0]    r_mem_wd;

  logic          w_any_req, w_grant, w_ack_fire, w_done_fire, w_rr_found;
  logic [IW-1:0] w_rr_idx, w_winner, w_sel_inc;
  logic [IW:0]   w_cand;

  assign w_any_req = |bus.req;
  assign w_sel_inc = (r_sel == IW'(N - 1)) ? '0 : r_sel + 1'b1;

  // First set request at or above ptr, wrapping modulo N.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_cand     = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = {1'b0, r_ptr} + (IW + 1)'(k);
      if (w_cand >= (IW + 1)'(N)) w_cand = w_cand - (IW + 1)'(N);
      if (!w_rr_found && bus.req[w_cand[IW-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_cand[IW-1:0];
      end
    end
  end

`ifdef DMA_ARB_BURST_EN
  logic [7:0] r_burst_cnt;
  logic       w_burst_keep;

  assign w_burst_keep = bus.req[r_sel] && (r_burst_cnt < 8'(BURST_MAX));
  assign w_winner     = w_burst_keep ? r_sel : w_rr_idx;

  always_ff @(posedge clk) begin
    if (rst)          r_burst_cnt <= 8'd0;
    else if (w_grant) r_burst_cnt <= w_burst_keep ? r_burst_cnt + 8'd1 : 8'd1;
  end
`else
  assign w_winner = w_rr_idx;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req)    w_next_state = S_ISSUE;
      S_ISSUE: if (bus.mem_ack)  w_next_state = S_WAIT;
      S_WAIT:  if (bus.mem_done) w_next_state = S_IDLE;
      default:                   w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_grant     = (r_state == S_IDLE)  && w_any_req;
    w_ack_fire  = (r_state == S_ISSUE) && bus.mem_ack;
    w_done_fire = (r_state == S_WAIT)  && bus.mem_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_sel      <= '0;
      r_ack      <= '0;
      r_done     <= '0;
      r_rd       <= 8'd0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_mem_rnw  <= 1'b1;
      r_mem_wd   <= 8'd0;
    end else begin
      r_ack  <= '0;
      r_done <= '0;
      if (w_grant) begin
        r_sel      <= w_winner;
        r_mem_addr <= bus.addr[int'(w_winner)*AW +: AW];
        r_mem_rnw  <= bus.rnw[w_winner];
        r_mem_wd   <= bus.wd[int'(w_winner)*8 +: 8];
        r_mem_req  <= 1'b1;
      end
      if (w_ack_fire) begin
        r_mem_req    <= 1'b0;
        r_ack[r_sel] <= 1'b1;
        r_ptr        <= w_sel_inc;
      end
      // Writes leave the shared read register untouched.
      if (w_done_fire) begin
        r_done[r_sel] <= 1'b1;
        if (r_mem_rnw) r_rd <= bus.mem_rd;
      end
    end
  end

  assign bus.ack      = r_ack;
  assign bus.done     = r_done;
  assign bus.rd       = r_rd;
  assign bus.mem_req  = r_mem_req;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_rnw  = r_mem_rnw;
  assign bus.mem_wd   = r_mem_wd;
  assign o_state      = r_state;
endmodule

// File: tb/tb_dma_arbiter.sv
// Directed bench for dma_arbiter: reset, single read, write, rotation, delayed ack, mid-transfer reset.
module tb_dma_arbiter;
  localparam int N  = 4;
  localparam int AW = 22;

  typedef int order_t[9];

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state;
  int         checks = 0;
  int         errors = 0;
  logic [AW-1:0] tb_addr[N];

  always #5 clk = ~clk;

  dma_arbiter_if #(.N(N), .AW(AW)) bus();

  dma_arbiter #(.N(N), .AW(AW), .BURST_MAX(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (state)
  );

  task automatic do_reset();
    rst          = 1'b1;
    bus.req      = '0;
    bus.addr     = '0;
    bus.rnw      = '1;
    bus.wd       = '0;
    bus.mem_ack  = 1'b0;
    bus.mem_done = 1'b0;
    bus.mem_rd   = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 2'd0)          begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (bus.ack !== 4'b0)        begin errors++; $display("FAIL reset_ack: got %b expected 0000", bus.ack); end
    checks++; if (bus.done !== 4'b0)       begin errors++; $display("FAIL reset_done: got %b expected 0000", bus.done); end
    checks++; if (bus.rd !== 8'h00)        begin errors++; $display("FAIL reset_rd: got %h expected 00", bus.rd); end
    checks++; if (bus.mem_req !== 1'b0)    begin errors++; $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
    checks++; if (bus.mem_addr !== 22'h0)  begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
    checks++; if (bus.mem_rnw !== 1'b1)    begin errors++; $display("FAIL reset_mem_rnw: got %b expected 1", bus.mem_rnw); end
    checks++; if (bus.mem_wd !== 8'h00)    begin errors++; $display("FAIL reset_mem_wd: got %h expected 00", bus.mem_wd); end
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b0)    begin errors++; $display("FAIL idle_no_req: got %b expected 0", bus.mem_req); end
  endtask

  task automatic test_single_read();
    do_reset();
    bus.req[2] = 1'b1;
    bus.addr[2*AW +: AW] = 22'h012345;
    bus.rnw[2] = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1)          begin errors++; $display("FAIL single_mem_req: got %b expected 1", bus.mem_req); end
    checks++; if (bus.mem_addr !== 22'h012345)   begin errors++; $display("FAIL single_mem_addr: got %h expected 012345", bus.mem_addr); end
    checks++; if (bus.mem_rnw !== 1'b1)          begin errors++; $display("FAIL single_mem_rnw: got %b expected 1", bus.mem_rnw); end
    checks++; if (bus.ack !== 4'b0)              begin errors++; $display("FAIL single_early_ack: got %b expected 0000", bus.ack); end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    checks++; if (bus.ack !== 4'b0100)           begin errors++; $display("FAIL single_ack: got %b expected 0100", bus.ack); end
    checks++; if (bus.mem_req !== 1'b0)          begin errors++; $display("FAIL single_mem_req_drop: got %b expected 0", bus.mem_req); end
    bus.mem_ack  = 1'b0;
    bus.mem_done = 1'b1;
    bus.mem_rd   = 8'hA5;
    bus.req      = '0;
    @(negedge clk);
    checks++; if (bus.done !== 4'b0100)          begin errors++; $display("FAIL single_done: got %b expected 0100", bus.done); end
    checks++; if (bus.rd !== 8'hA5)              begin errors++; $display("FAIL single_rd: got %h expected a5", bus.rd); end
    bus.mem_done = 1'b0;
    @(negedge clk);
    checks++; if (bus.done !== 4'b0)             begin errors++; $display("FAIL single_done_pulse: got %b expected 0000", bus.done); end
    checks++; if (bus.mem_req !== 1'b0)          begin errors++; $display("FAIL single_idle: got %b expected 0", bus.mem_req); end
  endtask

  // Follows test_single_read without reset so rd still holds a5.
  task automatic test_write();
    bus.req[1] = 1'b1;
    bus.addr[1*AW +: AW] = 22'h2ABCDE;
    bus.wd[1*8 +: 8] = 8'h3C;
    bus.rnw[1] = 1'b0;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1)         begin errors++; $display("FAIL write_mem_req: got %b expected 1", bus.mem_req); end
    checks++; if (bus.mem_wd !== 8'h3C)         begin errors++; $display("FAIL write_mem_wd: got %h expected 3c", bus.mem_wd); end
    checks++; if (bus.mem_rnw !== 1'b0)         begin errors++; $display("FAIL write_mem_rnw: got %b expected 0", bus.mem_rnw); end
    checks++; if (bus.mem_addr !== 22'h2ABCDE)  begin errors++; $display("FAIL write_mem_addr: got %h expected 2abcde", bus.mem_addr); end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    checks++; if (bus.ack !== 4'b0010)          begin errors++; $display("FAIL write_ack: got %b expected 0010", bus.ack); end
    bus.mem_ack  = 1'b0;
    bus.mem_done = 1'b1;
    bus.mem_rd   = 8'h5A;
    bus.req      = '0;
    @(negedge clk);
    checks++; if (bus.done !== 4'b0010)         begin errors++; $display("FAIL write_done: got %b expected 0010", bus.done); end
    checks++; if (bus.rd !== 8'hA5)             begin errors++; $display("FAIL write_rd_held: got %h expected a5", bus.rd); end
    bus.mem_done = 1'b0;
    bus.rnw      = '1;
    @(negedge clk);
  endtask

  // Downstream answers immediately; checks grant order, addresses and 3-cycle spacing.
  task automatic run_grant_order(input string name, input logic [N-1:0] reqs, input int n, input order_t order);
    int n_ack;
    int last;
    do_reset();
    for (int i = 0; i < N; i++) begin
      tb_addr[i] = AW'(22'h100000 + i * 22'h111);
      bus.addr[i*AW +: AW] = tb_addr[i];
    end
    bus.req = reqs;
    n_ack = 0;
    last  = -1;
    for (int cyc = 0; cyc < 60 && n_ack < n; cyc++) begin
      @(negedge clk);
      bus.mem_done = 1'b0;
      if (bus.mem_req === 1'b1) begin
        checks++;
        if (bus.mem_addr !== tb_addr[order[n_ack]]) begin
          errors++; $display("FAIL %s_addr[%0d]: got %h expected %h", name, n_ack, bus.mem_addr, tb_addr[order[n_ack]]);
        end
      end
      if (bus.ack !== 4'b0) begin
        checks++;
        if (bus.ack !== (4'b0001 << order[n_ack])) begin
          errors++; $display("FAIL %s_ack[%0d]: got %b expected %b", name, n_ack, bus.ack, 4'b0001 << order[n_ack]);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 3) begin
            errors++; $display("FAIL %s_spacing[%0d]: got %0d cycles expected 3", name, n_ack, cyc - last);
          end
        end
        last = cyc;
        n_ack++;
        bus.mem_done = 1'b1;
        if (n_ack == n) bus.req = '0;
      end
      bus.mem_ack = bus.mem_req;
    end
    checks++;
    if (n_ack != n) begin
      errors++; $display("FAIL %s_count: got %0d acks expected %0d", name, n_ack, n);
    end
    @(negedge clk);
    bus.mem_done = 1'b0;
    bus.mem_ack  = 1'b0;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL %s_idle: got %b expected 0", name, bus.mem_req); end
  endtask

  task automatic test_round_robin();
    run_grant_order("rr_all", 4'b1111, 6, '{0, 1, 2, 3, 0, 1, 0, 0, 0});
  endtask

  task automatic test_pair();
`ifdef DMA_ARB_BURST_EN
    run_grant_order("burst", 4'b1001, 9, '{0, 0, 0, 0, 3, 3, 3, 3, 0});
`else
    run_grant_order("rr_pair", 4'b1001, 6, '{0, 3, 0, 3, 0, 3, 0, 0, 0});
`endif
  endtask

  task automatic test_delayed_ack();
    do_reset();
    bus.req[0] = 1'b1;
    bus.addr[0 +: AW] = 22'h0155AA;
    bus.rnw[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (bus.mem_req !== 1'b1)        begin errors++; $display("FAIL delay_mem_req[%0d]: got %b expected 1", i, bus.mem_req); end
      checks++; if (bus.mem_addr !== 22'h0155AA) begin errors++; $display("FAIL delay_mem_addr[%0d]: got %h expected 0155aa", i, bus.mem_addr); end
      checks++; if (bus.ack !== 4'b0)            begin errors++; $display("FAIL delay_ack[%0d]: got %b expected 0000", i, bus.ack); end
      checks++; if (bus.done !== 4'b0)           begin errors++; $display("FAIL delay_done[%0d]: got %b expected 0000", i, bus.done); end
      bus.mem_done = (i == 2);
    end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    checks++; if (bus.ack !== 4'b0001) begin errors++; $display("FAIL delay_ack_final: got %b expected 0001", bus.ack); end
    bus.mem_ack  = 1'b0;
    bus.mem_done = 1'b1;
    bus.mem_rd   = 8'hC3;
    bus.req      = '0;
    @(negedge clk);
    checks++; if (bus.done !== 4'b0001) begin errors++; $display("FAIL delay_done_final: got %b expected 0001", bus.done); end
    checks++; if (bus.rd !== 8'hC3)     begin errors++; $display("FAIL delay_rd: got %h expected c3", bus.rd); end
    bus.mem_done = 1'b0;
    @(negedge clk);
  endtask

  // Follows test_delayed_ack without reset so rd holds c3 before the abort.
  task automatic test_reset_mid();
    bus.req[3] = 1'b1;
    bus.addr[3*AW +: AW] = 22'h3FFFFF;
    bus.rnw[3] = 1'b0;
    bus.wd[3*8 +: 8] = 8'h81;
    @(negedge clk);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    checks++; if (bus.ack !== 4'b1000) begin errors++; $display("FAIL mid_ack: got %b expected 1000", bus.ack); end
    checks++; if (state !== 2'd2)      begin errors++; $display("FAIL mid_state_wait: got %0d expected 2", state); end
    rst         = 1'b1;
    bus.mem_ack = 1'b0;
    bus.req     = '0;
    @(negedge clk);
    checks++; if (state !== 2'd0)          begin errors++; $display("FAIL mid_state: got %0d expected 0", state); end
    checks++; if (bus.rd !== 8'h00)        begin errors++; $display("FAIL mid_rd: got %h expected 00", bus.rd); end
    checks++; if (bus.mem_addr !== 22'h0)  begin errors++; $display("FAIL mid_mem_addr: got %h expected 0", bus.mem_addr); end
    checks++; if (bus.mem_rnw !== 1'b1)    begin errors++; $display("FAIL mid_mem_rnw: got %b expected 1", bus.mem_rnw); end
    checks++; if (bus.mem_wd !== 8'h00)    begin errors++; $display("FAIL mid_mem_wd: got %h expected 00", bus.mem_wd); end
    checks++; if (bus.mem_req !== 1'b0)    begin errors++; $display("FAIL mid_mem_req: got %b expected 0", bus.mem_req); end
    checks++; if (bus.ack !== 4'b0)        begin errors++; $display("FAIL mid_ack_clr: got %b expected 0000", bus.ack); end
    checks++; if (bus.done !== 4'b0)       begin errors++; $display("FAIL mid_done_clr: got %b expected 0000", bus.done); end
    rst          = 1'b0;
    bus.mem_done = 1'b1;
    bus.mem_rd   = 8'hEE;
    @(negedge clk);
    checks++; if (bus.done !== 4'b0)   begin errors++; $display("FAIL mid_late_done: got %b expected 0000", bus.done); end
    checks++; if (bus.rd !== 8'h00)    begin errors++; $display("FAIL mid_late_rd: got %h expected 00", bus.rd); end
    checks++; if (state !== 2'd0)      begin errors++; $display("FAIL mid_late_state: got %0d expected 0", state); end
    bus.mem_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_pair();
    test_delayed_ack();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/dma_arbiter.md
# dma_arbiter

Round-robin arbiter that shares the single main-memory DMA port between up to eight DMA requesters (SD-card DMA, MP3 DMA, etc.). Each requester sees the same one-shot req/ack/end handshake it would see from a dedicated port. The arbiter latches the winner's address, direction and write data, issues one byte transfer downstream, and routes completion back. It sits between the per-device DMA controllers and the memory access sequencer.

## Interface
Parameters:
- N, 4: number of requesters, 2..8; index width IW = clog2(N)
- AW, 22: DMA address width
- BURST_MAX, 16: max consecutive grants to one requester (used only with DMA_ARB_BURST_EN), 1..255

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- req  in  N  per-requester transfer request, level
- addr  in  N*AW  packed addresses; requester i at [i*AW +: AW]
- rnw  in  N  1 = read memory, 0 = write memory
- wd  in  N*8  packed write data
- ack  out  N  one-cycle pulse: requester's transfer accepted; requester may change addr/wd/rnw
- done  out  N  one-cycle pulse: transfer finished; rd valid for reads
- rd  out  8  read data of the last completed read, shared; held until next completion
- mem_req  out  1  downstream request, level
- mem_addr  out  AW  latched address
- mem_rnw  out  1  latched direction
- mem_wd  out  8  latched write data
- mem_ack  in  1  downstream accepted the request (sampled while mem_req=1)
- mem_done  in  1  downstream finished; mem_rd valid in same cycle for reads
- mem_rd  in  8  downstream read data

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any req bit set, select winner = first set bit searching from ptr upward, wrapping mod N. Register sel, mem_addr, mem_rnw, mem_wd from the winner; set mem_req=1; go ISSUE. Else stay.
- ISSUE: hold mem_req and latched fields. On mem_ack: mem_req<=0, ack[sel]<=1 for one cycle, ptr <= (sel+1) mod N, go WAIT.
- WAIT: on mem_done: done[sel]<=1 for one cycle; if mem_rnw, rd<=mem_rd (writes leave rd unchanged); go IDLE.
- Requester protocol: hold req, addr, rnw and wd stable until ack. If req drops before ack, the latched transfer still completes and ack/done still pulse.
- Downstream protocol: mem_done arrives at least one cycle after mem_ack. mem_done outside WAIT and mem_ack outside ISSUE are ignored.
- At most one transfer outstanding. At most one ack bit and one done bit high in any cycle.
- Reset values: state=IDLE, ptr=0, sel=0, ack=0, done=0, rd=0, mem_req=0, mem_addr=0, mem_rnw=1, mem_wd=0.
- Reset mid-transfer: everything returns to reset values next cycle. The outstanding transfer is abandoned; no ack or done is issued for it.

## Timing
- req rises in cycle 0 (IDLE): mem_req=1 with valid fields in cycle 1.
- mem_ack in cycle k: ack[sel] high in cycle k+1, mem_req low in cycle k+1.
- mem_done in cycle m: done[sel] and updated rd in cycle m+1. Arbitration occurs in cycle m+1, so the next mem_req rises in cycle m+2.
- Best-case throughput: one transfer per 3 cycles (mem_ack in cycle 1, mem_done in cycle 2).
- Fairness without burst: with all N requesting continuously, grants rotate 0,1,...,N-1,0. The worst-case wait is N-1 transfers.

## Configuration
- DMA_ARB_BURST_EN defined:
  - In IDLE, if the previous winner still has req=1 and burst count < BURST_MAX, it wins again regardless of ptr; count increments.
  - Otherwise normal round-robin applies and count resets to 1 on the new winner.
  - The count is 8 bits and resets to 0.
- DMA_ARB_BURST_EN undefined: pure round-robin after every transfer. No burst counter logic is present; BURST_MAX is ignored.

## Test plan
- Single requester: req[2]=1, addr=22'h012345, rnw=1; mem_ack in cycle 1, mem_done in cycle 2 with mem_rd=8'hA5 -> mem_addr=22'h012345 in cycle 1, ack=4'b0100 in cycle 2, done=4'b0100 and rd=8'hA5 in cycle 3.
- All four requesting, burst off, mem_ack/mem_done immediate -> ack pulse order 0,1,2,3,0,1 with one transfer every 3 cycles.
- Write from requester 1: wd=8'h3C, rnw=0, rd previously 8'hA5 -> mem_wd=8'h3C, mem_rnw=0, done[1] pulses, rd stays 8'hA5.
- Burst on, BURST_MAX=4, requesters 0 and 3 held high -> grants 0,0,0,0,3,3,3,3,0.
- mem_ack delayed 5 cycles -> mem_req and fields stay stable throughout; no ack pulse before the delayed mem_ack.
- rst asserted in WAIT -> next cycle all outputs at reset values; a later mem_done produces no done pulse.
